// File: rtl/fpu_div_frac_seq_if.sv
// rtl/fpu_div_frac_seq_if.sv - divide request/handshake bundle between issue logic and sequencer
interface fpu_div_frac_seq_if;
    logic div_req;
    logic div_dbl;
    logic div_special;
    logic div_kill;
    logic div_ready;
    logic div_done;

    // Issue logic side
    modport master (
        output div_req,
        output div_dbl,
        output div_special,
        output div_kill,
        input  div_ready,
        input  div_done
    );

    // Sequencer side
    modport slave (
        input  div_req,
        input  div_dbl,
        input  div_special,
        input  div_kill,
        output div_ready,
        output div_done
    );
endinterface

// File: rtl/fpu_div_frac_seq.sv
// rtl/fpu_div_frac_seq.sv - divide-pipe fraction datapath sequencer
module fpu_div_frac_seq #(
    parameter int ITER_DBL = 55,
    parameter int ITER_SNG = 26
) (
    input  logic                      rclk,
    input  logic                      reset,
    fpu_div_frac_seq_if.slave         div_if,
    output logic                      d1stg_step,
    output logic                      d3stg_fdiv,
    output logic                      d4stg_fdiv,
    output logic                      d5stg_fdivb,
    output logic                      d6stg_fdiv,
    output logic                      d6stg_fdivd,
    output logic                      d6stg_fdivs,
    output logic                      div_frac_add_in1_add,
    output logic                      div_frac_add_in1_load,
    output logic                      div_frac_add_in2_load,
    output logic                      div_frac_out_shl1_dbl,
    output logic                      div_frac_out_shl1_sng,
    output logic                      div_frac_out_add,
    output logic                      div_frac_out_load,
    output logic                      fdiv_clken_l
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_D1,
        S_D2,
        S_D3,
        S_D4,
        S_ITER,
        S_D6,
        S_D7,
        S_DONE
    } state_t;

    // Counter holds iterations remaining after the current one, so load N-1
    localparam logic [5:0] LOAD_DBL = 6'(ITER_DBL - 1);
    localparam logic [5:0] LOAD_SNG = 6'(ITER_SNG - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       dbl_q, dbl_d;
    logic       special_q, special_d;
    logic       accept;

    assign accept = (state_q == S_IDLE) && div_if.div_req && !div_if.div_kill;

    // State, iteration counter and latched request flags
    always_ff @(posedge rclk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            dbl_q     <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dbl_q     <= dbl_d;
            special_q <= special_d;
        end
    end

    // Next-state: fixed stage walk, counted iterations, kill flushes to idle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dbl_d     = dbl_q;
        special_d = special_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_D1;
                    dbl_d     = div_if.div_dbl;
                    special_d = div_if.div_special;
                end
            end
            S_D1: state_d = S_D2;
            S_D2: state_d = S_D3;
            S_D3: state_d = S_D4;
            S_D4: begin
                if (special_q) begin
                    state_d = S_D6;
                end else begin
                    state_d = S_ITER;
                    cnt_d   = dbl_q ? LOAD_DBL : LOAD_SNG;
                end
            end
            S_ITER: begin
                if (cnt_q == 6'd0) begin
                    state_d = S_D6;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_D6:   state_d = S_D7;
            S_D7:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (div_if.div_kill && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
        end
    end

    // Strobe decode from registered state; everything forced low while in reset
    always_comb begin
        d3stg_fdiv            = 1'b0;
        d4stg_fdiv            = 1'b0;
        d5stg_fdivb           = 1'b0;
        d6stg_fdiv            = 1'b0;
        d6stg_fdivd           = 1'b0;
        d6stg_fdivs           = 1'b0;
        div_frac_add_in1_add  = 1'b0;
        div_frac_add_in1_load = 1'b0;
        div_frac_add_in2_load = 1'b0;
        div_frac_out_shl1_dbl = 1'b0;
        div_frac_out_shl1_sng = 1'b0;
        div_frac_out_add      = 1'b0;
        div_frac_out_load     = 1'b0;
        div_if.div_done       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_D3: d3stg_fdiv = 1'b1;
                S_D4: begin
                    // Result register load here with nothing selected clears it
                    d4stg_fdiv            = 1'b1;
                    div_frac_add_in1_load = 1'b1;
                    div_frac_add_in2_load = 1'b1;
                    div_frac_out_load     = 1'b1;
                end
                S_ITER: begin
                    d5stg_fdivb           = 1'b1;
                    div_frac_add_in1_add  = 1'b1;
                    div_frac_add_in1_load = 1'b1;
                    div_frac_out_load     = 1'b1;
                    div_frac_out_shl1_dbl = dbl_q;
                    div_frac_out_shl1_sng = !dbl_q;
                end
                S_D6: begin
                    d6stg_fdiv            = 1'b1;
                    d6stg_fdivd           = dbl_q;
                    d6stg_fdivs           = !dbl_q;
                    div_frac_add_in1_load = 1'b1;
                    div_frac_add_in2_load = 1'b1;
                end
                S_D7: begin
                    div_frac_out_add  = 1'b1;
                    div_frac_out_load = 1'b1;
                end
                S_DONE: div_if.div_done = 1'b1;
                default: ;
            endcase
        end
    end

    // Operand capture fires in the accept cycle itself
    assign d1stg_step       = accept && !reset;
    assign div_if.div_ready = (state_q == S_IDLE) && !reset;
    assign fdiv_clken_l     = !(reset || (state_q != S_IDLE) || div_if.div_req);

endmodule

// File: tb/tb_fpu_div_frac_seq.sv
// tb/tb_fpu_div_frac_seq.sv - directed self-checking bench for fpu_div_frac_seq
module tb_fpu_div_frac_seq;
    logic rclk;
    logic reset;
    logic d1stg_step, d3stg_fdiv, d4stg_fdiv, d5stg_fdivb, d6stg_fdiv;
    logic d6stg_fdivd, d6stg_fdivs;
    logic div_frac_add_in1_add, div_frac_add_in1_load, div_frac_add_in2_load;
    logic div_frac_out_shl1_dbl, div_frac_out_shl1_sng, div_frac_out_add, div_frac_out_load;
    logic fdiv_clken_l;

    fpu_div_frac_seq_if div_if ();

    fpu_div_frac_seq #(.ITER_DBL(55), .ITER_SNG(26)) dut (
        .rclk                  (rclk),
        .reset                 (reset),
        .div_if                (div_if.slave),
        .d1stg_step            (d1stg_step),
        .d3stg_fdiv            (d3stg_fdiv),
        .d4stg_fdiv            (d4stg_fdiv),
        .d5stg_fdivb           (d5stg_fdivb),
        .d6stg_fdiv            (d6stg_fdiv),
        .d6stg_fdivd           (d6stg_fdivd),
        .d6stg_fdivs           (d6stg_fdivs),
        .div_frac_add_in1_add  (div_frac_add_in1_add),
        .div_frac_add_in1_load (div_frac_add_in1_load),
        .div_frac_add_in2_load (div_frac_add_in2_load),
        .div_frac_out_shl1_dbl (div_frac_out_shl1_dbl),
        .div_frac_out_shl1_sng (div_frac_out_shl1_sng),
        .div_frac_out_add      (div_frac_out_add),
        .div_frac_out_load     (div_frac_out_load),
        .fdiv_clken_l          (fdiv_clken_l)
    );

    localparam int B_D1 = 0, B_D3 = 1, B_D4 = 2, B_D5B = 3, B_D6 = 4, B_D6D = 5, B_D6S = 6;
    localparam int B_ADD = 7, B_IN1L = 8, B_IN2L = 9, B_SHD = 10, B_SHS = 11;
    localparam int B_OADD = 12, B_OLD = 13, B_RDY = 14, B_DONE = 15, B_CLK = 16;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] obs [0:127];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] snap();
        return {fdiv_clken_l, div_if.div_done, div_if.div_ready, div_frac_out_load,
                div_frac_out_add, div_frac_out_shl1_sng, div_frac_out_shl1_dbl,
                div_frac_add_in2_load, div_frac_add_in1_load, div_frac_add_in1_add,
                d6stg_fdivs, d6stg_fdivd, d6stg_fdiv, d5stg_fdivb, d4stg_fdiv,
                d3stg_fdiv, d1stg_step};
    endfunction

    function automatic int cnt(input int b, input int n);
        int k = 0;
        for (int i = 0; i < n; i++) if (obs[i][b]) k++;
        return k;
    endfunction

    function automatic int first(input int b, input int n);
        for (int i = 0; i < n; i++) if (obs[i][b]) return i;
        return -1;
    endfunction

    function automatic int last(input int b, input int n);
        int r = -1;
        for (int i = 0; i < n; i++) if (obs[i][b]) r = i;
        return r;
    endfunction

    // Entered and left #1 after a rising edge; cycle 0 is the request cycle
    task automatic run(input logic dbl, input logic sp, input logic hold,
                       input int kill_at, input int reset_at, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            div_if.div_req     = (c == 0) || hold;
            div_if.div_dbl     = dbl;
            div_if.div_special = sp;
            div_if.div_kill    = (c == kill_at);
            reset              = (c == reset_at);
            @(negedge rclk);
            obs[c] = snap();
            @(posedge rclk);
            #1;
        end
        div_if.div_req  = 1'b0;
        div_if.div_kill = 1'b0;
        reset           = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        div_if.div_req     = 1'b0;
        div_if.div_dbl     = 1'b0;
        div_if.div_special = 1'b0;
        div_if.div_kill    = 1'b0;
        @(posedge rclk);
        @(posedge rclk);
        #1;
        @(negedge rclk);
        check_eq("rst_strobes", int'(snap() & 17'h0BFFF), 0);
        check_eq("rst_ready", int'(div_if.div_ready), 0);
        check_eq("rst_clken_l", int'(fdiv_clken_l), 0);
        @(posedge rclk);
        #1;
        reset = 1'b0;
        @(posedge rclk);
        #1;
        @(negedge rclk);
        check_eq("post_rst_ready", int'(div_if.div_ready), 1);
        check_eq("post_rst_clken_l", int'(fdiv_clken_l), 1);
        @(posedge rclk);
        #1;

        // Double precision
        run(1'b1, 1'b0, 1'b0, -1, -1, 64);
        check_eq("dbl_d1_at0", int'(obs[0][B_D1]), 1);
        check_eq("dbl_d3_at3", int'(obs[3][B_D3]), 1);
        check_eq("dbl_shl_cnt", cnt(B_SHD, 64), 55);
        check_eq("dbl_shl_first", first(B_SHD, 64), 5);
        check_eq("dbl_shl_last", last(B_SHD, 64), 59);
        check_eq("dbl_sng_cnt", cnt(B_SHS, 64), 0);
        check_eq("dbl_d6d_at", first(B_D6D, 64), 60);
        check_eq("dbl_oadd_at", first(B_OADD, 64), 61);
        check_eq("dbl_done_cnt", cnt(B_DONE, 64), 1);
        check_eq("dbl_done_at", first(B_DONE, 64), 62);
        check_eq("dbl_ready_63", int'(obs[63][B_RDY]), 1);
        check_eq("dbl_ready_cnt", cnt(B_RDY, 64), 2);
        check_eq("dbl_oload_cnt", cnt(B_OLD, 64), 57);
        check_eq("dbl_in2l_cnt", cnt(B_IN2L, 64), 2);
        check_eq("dbl_clken_hi", cnt(B_CLK, 64), 1);

        // Single precision
        run(1'b0, 1'b0, 1'b0, -1, -1, 36);
        check_eq("sng_shl_cnt", cnt(B_SHS, 36), 26);
        check_eq("sng_shl_first", first(B_SHS, 36), 5);
        check_eq("sng_dbl_cnt", cnt(B_SHD, 36), 0);
        check_eq("sng_d6s_at", first(B_D6S, 36), 31);
        check_eq("sng_d6d_cnt", cnt(B_D6D, 36), 0);
        check_eq("sng_done_at", first(B_DONE, 36), 33);

        // Special double skips iterations
        run(1'b1, 1'b1, 1'b0, -1, -1, 10);
        check_eq("spc_d5b_cnt", cnt(B_D5B, 10), 0);
        check_eq("spc_d6_at", first(B_D6, 10), 5);
        check_eq("spc_done_at", first(B_DONE, 10), 7);
        check_eq("spc_ready_8", int'(obs[8][B_RDY]), 1);

        // Kill during iteration cycle 20
        run(1'b1, 1'b0, 1'b0, 20, -1, 40);
        check_eq("kill_d5b_cnt", cnt(B_D5B, 40), 16);
        check_eq("kill_done_cnt", cnt(B_DONE, 40), 0);
        check_eq("kill_ready_21", int'(obs[21][B_RDY]), 1);
        run(1'b1, 1'b0, 1'b0, -1, -1, 64);
        check_eq("kill_next_done_at", first(B_DONE, 64), 62);

        // Reset asserted in D4
        run(1'b0, 1'b0, 1'b0, -1, 4, 8);
        check_eq("rst4_d3_at3", int'(obs[3][B_D3]), 1);
        check_eq("rst4_strobes", int'(obs[4] & 17'h0BFFF), 0);
        check_eq("rst4_ready", int'(obs[4][B_RDY]), 0);
        check_eq("rst4_clken_l", int'(obs[4][B_CLK]), 0);
        check_eq("rst4_ready_5", int'(obs[5][B_RDY]), 1);
        check_eq("rst4_clken_5", int'(obs[5][B_CLK]), 1);
        check_eq("rst4_d4_cnt", cnt(B_D4, 8), 0);
        run(1'b0, 1'b0, 1'b0, -1, -1, 36);
        check_eq("rst4_new_done_at", first(B_DONE, 36), 33);

        // Request held through a whole op, then kill alongside request in idle
        run(1'b1, 1'b0, 1'b1, -1, -1, 63);
        check_eq("hold_accepts", cnt(B_D1, 63), 1);
        check_eq("hold_clken_hi", cnt(B_CLK, 63), 0);
        check_eq("hold_done_at", first(B_DONE, 63), 62);
        run(1'b1, 1'b0, 1'b0, 0, -1, 3);
        check_eq("killidle_d1", cnt(B_D1, 3), 0);
        check_eq("killidle_clken0", int'(obs[0][B_CLK]), 0);
        check_eq("killidle_ready_1", int'(obs[1][B_RDY]), 1);
        check_eq("killidle_d3_cnt", cnt(B_D3, 3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
